// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one single-ported RAM between the instruction-fetch path and the
//   data path. A registered grant state machine (IDLE / IGRANT / DGRANT)
//   sequences each access. Data wins arbitration unless an instruction fetch
//   has already waited through STARVE_MAX back-to-back data grants.
//
// Ports
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   iREN, iaddr         instruction read request and address
//   iwait, iload        instruction stall (low only on completion), fetched word
//   dREN, dWEN          data read / write request (both high = write)
//   daddr, dstore       data address and write data
//   dwait, dload        data stall (low only on completion), read data
//   ramREN, ramWEN      RAM read / write strobes
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   ram_err             sticky flag, set when the RAM reports ERROR mid-grant
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int SCNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IGRANT = 2'd1;
    localparam logic [1:0] ST_DGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_MAX);
    localparam logic [SCNT_W-1:0] SCNT_ZERO = {SCNT_W{1'b0}};
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1'b1);

    logic [1:0]        state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              ram_err_q, ram_err_d;

    logic       dreq_s;
    logic       access_s;
    logic       i_done_s;
    logic       d_done_s;
    logic [1:0] arb_s;

    // Request decode and per-requester completion detection.
    always_comb begin
        dreq_s   = dREN | dWEN;
        access_s = (ramstate == RAM_ACCESS);
        i_done_s = (state_q == ST_IGRANT) && access_s;
        d_done_s = (state_q == ST_DGRANT) && access_s;
    end

    // Starvation counter: counts data completions that overtook a pending fetch.
    always_comb begin
        scnt_d = scnt_q;
        if (!iREN) begin
            scnt_d = SCNT_ZERO;
        end else if (i_done_s) begin
            scnt_d = SCNT_ZERO;
        end else if (d_done_s && (scnt_q != SCNT_MAX)) begin
            scnt_d = scnt_q + SCNT_ONE;
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Arbitration. It looks at the count as it will stand after this edge, so
    // the completion that brings the count to STARVE_MAX hands over to the fetch.
    always_comb begin
        arb_s = ST_IDLE;
        if (dreq_s && !(iREN && (scnt_d == SCNT_MAX))) begin
            arb_s = ST_DGRANT;
        end else if (iREN) begin
            arb_s = ST_IGRANT;
        end else begin
            arb_s = ST_IDLE;
        end
    end

    // Next grant: re-arbitrate on completion or withdrawal, otherwise hold
    // (BUSY, FREE and ERROR all keep the grant so the access is retried).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = arb_s;
            end
            ST_IGRANT: begin
                if (access_s || !iREN) begin
                    state_d = arb_s;
                end else begin
                    state_d = ST_IGRANT;
                end
            end
            ST_DGRANT: begin
                if (access_s || !dreq_s) begin
                    state_d = arb_s;
                end else begin
                    state_d = ST_DGRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error flag: any ERROR status seen while a grant is active.
    always_comb begin
        ram_err_d = ram_err_q;
        if ((state_q != ST_IDLE) && (ramstate == RAM_ERROR)) begin
            ram_err_d = 1'b1;
        end else begin
            ram_err_d = ram_err_q;
        end
    end

    // State, counter and error flag registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            scnt_q    <= SCNT_ZERO;
            ram_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            ram_err_q <= ram_err_d;
        end
    end

    // RAM-side strobes and address/data mux, decoded from the registered grant.
    // A simultaneous read and write request is issued as a write only.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {WORD_W{1'b0}};
        ramstore = {WORD_W{1'b0}};
        case (state_q)
            ST_IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            ST_DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: begin
                ramREN   = 1'b0;
                ramWEN   = 1'b0;
                ramaddr  = {WORD_W{1'b0}};
                ramstore = {WORD_W{1'b0}};
            end
        endcase
    end

    // Requester-side outputs: waits drop only in the completing cycle.
    always_comb begin
        iwait   = ~i_done_s;
        dwait   = ~d_done_s;
        iload   = ramload;
        dload   = ramload;
        ram_err = ram_err_q;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed bench for memory_arbiter. The bench plays the RAM by driving
//   ramstate/ramload directly. Inputs change on the falling edge and outputs
//   are sampled 1 ns later, well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int W = 32;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic         CLK;
    logic         nRST;
    logic         iREN;
    logic [W-1:0] iaddr;
    logic         iwait;
    logic [W-1:0] iload;
    logic         dREN;
    logic         dWEN;
    logic [W-1:0] daddr;
    logic [W-1:0] dstore;
    logic         dwait;
    logic [W-1:0] dload;
    logic         ramREN;
    logic         ramWEN;
    logic [W-1:0] ramaddr;
    logic [W-1:0] ramstore;
    logic [W-1:0] ramload;
    logic [1:0]   ramstate;
    logic         ram_err;

    int checks;
    int errors;

    memory_arbiter #(
        .WORD_W    (W),
        .STARVE_MAX(4)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .ram_err (ram_err)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic next_cycle();
        @(negedge CLK);
    endtask

    // Stimulus and checks.
    initial begin
        checks   = 0;
        errors   = 0;
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        ramload  = 32'h0;
        ramstate = RS_FREE;

        // ---- reset state ----
        next_cycle();
        #1;
        check_eq("rst_ramREN",  32'(ramREN),  32'd0);
        check_eq("rst_ramWEN",  32'(ramWEN),  32'd0);
        check_eq("rst_ramaddr", ramaddr,      32'h0);
        check_eq("rst_iwait",   32'(iwait),   32'd1);
        check_eq("rst_dwait",   32'(dwait),   32'd1);
        check_eq("rst_ram_err", 32'(ram_err), 32'd0);
        next_cycle();
        nRST = 1'b1;

        // ---- single fetch, ACCESS two cycles after the strobe ----
        next_cycle();
        iREN  = 1'b1;
        iaddr = 32'h40;
        #1;
        check_eq("if_idle_ramREN", 32'(ramREN), 32'd0);
        check_eq("if_idle_iwait",  32'(iwait),  32'd1);
        next_cycle();
        ramstate = RS_BUSY;
        #1;
        check_eq("if_s0_ramREN",  32'(ramREN), 32'd1);
        check_eq("if_s0_ramaddr", ramaddr,     32'h40);
        check_eq("if_s0_iwait",   32'(iwait),  32'd1);
        next_cycle();
        #1;
        check_eq("if_s1_ramREN", 32'(ramREN), 32'd1);
        check_eq("if_s1_iwait",  32'(iwait),  32'd1);
        next_cycle();
        ramstate = RS_ACCESS;
        ramload  = 32'h8C010004;
        #1;
        check_eq("if_s2_ramREN", 32'(ramREN), 32'd1);
        check_eq("if_s2_iwait",  32'(iwait),  32'd0);
        check_eq("if_s2_iload",  iload,       32'h8C010004);
        check_eq("if_s2_dwait",  32'(dwait),  32'd1);
        #1;
        iREN = 1'b0;
        next_cycle();
        ramstate = RS_FREE;
        #1;
        check_eq("if_after_iwait",  32'(iwait),  32'd1);
        check_eq("if_after_ramREN", 32'(ramREN), 32'd0);

        // ---- simultaneous fetch and write: write first, fetch with no bubble ----
        next_cycle();
        iREN   = 1'b1;
        iaddr  = 32'h40;
        dWEN   = 1'b1;
        daddr  = 32'h100;
        dstore = 32'hDEADBEEF;
        #1;
        check_eq("sim_idle_ramWEN", 32'(ramWEN), 32'd0);
        next_cycle();
        ramstate = RS_ACCESS;
        #1;
        check_eq("sim_d_ramWEN",   32'(ramWEN), 32'd1);
        check_eq("sim_d_ramREN",   32'(ramREN), 32'd0);
        check_eq("sim_d_ramaddr",  ramaddr,     32'h100);
        check_eq("sim_d_ramstore", ramstore,    32'hDEADBEEF);
        check_eq("sim_d_dwait",    32'(dwait),  32'd0);
        check_eq("sim_d_iwait",    32'(iwait),  32'd1);
        #1;
        dWEN = 1'b0;
        next_cycle();
        ramload = 32'h24020001;
        #1;
        check_eq("sim_i_ramREN",  32'(ramREN), 32'd1);
        check_eq("sim_i_ramWEN",  32'(ramWEN), 32'd0);
        check_eq("sim_i_ramaddr", ramaddr,     32'h40);
        check_eq("sim_i_iwait",   32'(iwait),  32'd0);
        check_eq("sim_i_iload",   iload,       32'h24020001);
        #1;
        iREN = 1'b0;
        next_cycle();
        ramstate = RS_FREE;
        #1;
        check_eq("sim_after_ramREN", 32'(ramREN), 32'd0);

        // ---- starvation bound: D,D,D,D,I repeating ----
        next_cycle();
        iREN     = 1'b1;
        iaddr    = 32'h80;
        dREN     = 1'b1;
        daddr    = 32'h200;
        ramstate = RS_ACCESS;
        #1;
        check_eq("stv_idle_ramREN", 32'(ramREN), 32'd0);
        for (int k = 0; k < 10; k++) begin
            logic is_i;
            is_i = ((k % 5) == 4);
            next_cycle();
            #1;
            check_eq($sformatf("stv_g%0d_iwait", k),   32'(iwait), 32'(!is_i));
            check_eq($sformatf("stv_g%0d_dwait", k),   32'(dwait), 32'(is_i));
            check_eq($sformatf("stv_g%0d_ramaddr", k), ramaddr,    is_i ? 32'h80 : 32'h200);
            if (k == 9) begin
                #1;
                iREN = 1'b0;
                dREN = 1'b0;
            end
        end
        next_cycle();
        ramstate = RS_FREE;
        #1;
        check_eq("stv_after_ramREN", 32'(ramREN), 32'd0);

        // ---- ERROR retry ----
        next_cycle();
        dREN  = 1'b1;
        daddr = 32'h300;
        #1;
        check_eq("err_idle_ram_err", 32'(ram_err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            ramstate = RS_ERROR;
            #1;
            check_eq($sformatf("err_e%0d_dwait", k),   32'(dwait),   32'd1);
            check_eq($sformatf("err_e%0d_ramREN", k),  32'(ramREN),  32'd1);
            check_eq($sformatf("err_e%0d_ramaddr", k), ramaddr,      32'h300);
            check_eq($sformatf("err_e%0d_ram_err", k), 32'(ram_err), (k == 0) ? 32'd0 : 32'd1);
        end
        next_cycle();
        ramstate = RS_ACCESS;
        ramload  = 32'h12345678;
        #1;
        check_eq("err_acc_dwait",   32'(dwait),   32'd0);
        check_eq("err_acc_dload",   dload,        32'h12345678);
        check_eq("err_acc_ram_err", 32'(ram_err), 32'd1);
        #1;
        dREN = 1'b0;
        next_cycle();
        ramstate = RS_FREE;
        #1;
        check_eq("err_after_ramREN",  32'(ramREN),  32'd0);
        check_eq("err_after_ram_err", 32'(ram_err), 32'd1);

        // ---- data request withdrawn while BUSY, fetch pending ----
        next_cycle();
        iREN  = 1'b1;
        iaddr = 32'hC0;
        dREN  = 1'b1;
        daddr = 32'h400;
        #1;
        check_eq("wd_idle_ramREN", 32'(ramREN), 32'd0);
        next_cycle();
        ramstate = RS_BUSY;
        #1;
        check_eq("wd_d_ramaddr", ramaddr,    32'h400);
        check_eq("wd_d_dwait",   32'(dwait), 32'd1);
        next_cycle();
        dREN = 1'b0;
        #1;
        check_eq("wd_drop_dwait", 32'(dwait), 32'd1);
        next_cycle();
        #1;
        check_eq("wd_i_ramREN",  32'(ramREN), 32'd1);
        check_eq("wd_i_ramaddr", ramaddr,     32'hC0);
        check_eq("wd_i_dwait",   32'(dwait),  32'd1);
        check_eq("wd_i_iwait",   32'(iwait),  32'd1);
        next_cycle();
        ramstate = RS_ACCESS;
        #1;
        check_eq("wd_acc_iwait", 32'(iwait), 32'd0);
        #1;
        iREN = 1'b0;
        next_cycle();
        ramstate = RS_FREE;

        // ---- reset mid-grant (read+write request issues as a write) ----
        next_cycle();
        dREN   = 1'b1;
        dWEN   = 1'b1;
        daddr  = 32'h500;
        dstore = 32'h55;
        next_cycle();
        ramstate = RS_BUSY;
        #1;
        check_eq("rmg_ramWEN",  32'(ramWEN),  32'd1);
        check_eq("rmg_ramREN",  32'(ramREN),  32'd0);
        check_eq("rmg_ram_err", 32'(ram_err), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        check_eq("rmg_rst_ramWEN",  32'(ramWEN),  32'd0);
        check_eq("rmg_rst_ramREN",  32'(ramREN),  32'd0);
        check_eq("rmg_rst_ramaddr", ramaddr,      32'h0);
        check_eq("rmg_rst_dwait",   32'(dwait),   32'd1);
        check_eq("rmg_rst_ram_err", 32'(ram_err), 32'd0);
        next_cycle();
        nRST = 1'b1;
        #1;
        check_eq("rmg_rel_ramWEN", 32'(ramWEN), 32'd0);
        next_cycle();
        ramstate = RS_ACCESS;
        #1;
        check_eq("rmg_regrant_ramWEN", 32'(ramWEN), 32'd1);
        check_eq("rmg_regrant_dwait",  32'(dwait),  32'd0);
        #1;
        dREN = 1'b0;
        dWEN = 1'b0;
        next_cycle();
        ramstate = RS_FREE;
        #1;
        check_eq("rmg_end_ramWEN", 32'(ramWEN), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
